// File: rtl/param_serial_mac_engine.sv
// Serial dot-product engine: loads one feature vector from a single-port RAM,
// then streams NUM_CH weight vectors against it, one MAC per cycle.
module param_serial_mac_engine #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int VEC_LEN     = 9,
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 20,
  parameter int SIGNED_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] feature_baseaddr,
  input  logic [ADDR_W-1:0] weight_baseaddr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              out_valid,
  output logic [3:0]        out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              done
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int FD = 1 << CW;

  typedef enum logic [2:0] {IDLE, LOAD_F, MAC, OUT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, kd;
  logic [3:0]        ch;
  logic [ADDR_W-1:0] wbase;
  logic [DATA_W-1:0] feat [FD];
  logic [ACC_W-1:0]  acc, fx, wx, prod;
  logic              last_k, issue_more, last_ch, fs, ws;

  // cnt counts issue slots; the data returned for slot k arrives at cnt=k+1
  assign kd         = cnt - CW'(1);
  assign last_k     = (cnt == CW'(VEC_LEN));
  assign issue_more = (cnt < CW'(VEC_LEN - 1));
  assign last_ch    = (ch == 4'(NUM_CH - 1));

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign done      = (state == DONE);

  // Extending both operands to ACC_W makes the truncated product exact mod 2^ACC_W
  always_comb begin
    fs   = (SIGNED_MODE != 0) && feat[kd][DATA_W-1];
    ws   = (SIGNED_MODE != 0) && mem_q[DATA_W-1];
    fx   = {{(ACC_W-DATA_W){fs}}, feat[kd]};
    wx   = {{(ACC_W-DATA_W){ws}}, mem_q};
    prod = fx * wx;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_F;
      LOAD_F:  if (last_k) state_nxt = MAC;
      MAC:     if (last_k) state_nxt = OUT;
      OUT:     state_nxt = last_ch ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ch       <= '0;
      acc      <= '0;
      wbase    <= '0;
      mem_addr <= '0;
      out_ch   <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          mem_addr <= feature_baseaddr;
          wbase    <= weight_baseaddr;
          cnt      <= '0;
          ch       <= '0;
          acc      <= '0;
        end
        LOAD_F: begin
          if (last_k) begin
            cnt      <= '0;
            mem_addr <= wbase;
          end else begin
            cnt <= cnt + CW'(1);
            if (issue_more) mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        MAC: begin
          if (last_k) begin
            cnt      <= '0;
            out_data <= acc + prod;
            out_ch   <= ch;
            acc      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt != '0) acc <= acc + prod;
            if (issue_more) mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        // Weights of consecutive channels are contiguous, so just step on
        OUT: if (!last_ch) begin
          ch       <= ch + 4'd1;
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD_F && cnt != '0) feat[kd] <= mem_q;
  end

endmodule
